axis_frame_ingress: RTL
=======================

# axis_frame_ingress

AXI4-Stream slave that converts a video stream (tuser = start of frame, tlast = end of line) into the flat pixel/valid/start-of-frame interface consumed by the 5x5 kernel line-buffer stage. It tracks column/row position against the configured geometry, flags framing errors, and discards pixels until the next start of frame after an error, so the kernel buffer never receives a misaligned line. It sits directly upstream of the kernel receiver in the median-filter pipeline.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width
- KERNEL_SIZE, 5, minimum legal IMAGE_WIDTH
- STAT_WIDTH, 16, width of statistics counters

Ports:
- i_clk  in  1  clock
- i_areset  in  1  asynchronous, active-high reset
- IMAGE_WIDTH  in  13  pixels per line; sampled on each accepted SOF beat
- IMAGE_HEIGHT  in  13  lines per frame; sampled on each accepted SOF beat
- i_enable  in  1  drives s_axis_tready
- s_axis_tdata  in  DATA_WIDTH  pixel
- s_axis_tvalid  in  1  beat valid
- s_axis_tuser  in  1  first pixel of frame
- s_axis_tlast  in  1  last pixel of line
- s_axis_tready  out  1  equals i_enable, combinational
- o_data  out  DATA_WIDTH  forwarded pixel
- o_data_valid  out  1  o_data valid this cycle
- o_start_of_frame  out  1  with pixel (0,0)
- o_end_of_frame  out  1  with pixel (W-1,H-1)
- o_err  out  3  one-cycle pulses: [0] early SOF, [1] short line, [2] long line
- o_cfg_err  out  1  level: latched geometry illegal

## Operation
- Accept = s_axis_tvalid & s_axis_tready. No back-pressure from downstream.
- States: IDLE, ACTIVE, DROP. Reset state IDLE.
- IDLE/DROP: non-tuser beats discarded (no o_data_valid). tuser beat: latch W/H, zero col/row; if W < KERNEL_SIZE or H == 0 set o_cfg_err, discard, stay IDLE; else forward with o_start_of_frame, clear o_cfg_err, go ACTIVE (col = 1).
- ACTIVE, each accepted beat forwarded, then:
  - tuser=1: o_err[0], treated as new SOF (relatch, position (0,0), o_start_of_frame).
  - tlast=1, col < W-1: o_err[1], go DROP.
  - tlast=0, col == W-1: o_err[2], go DROP.
  - tlast=1, col == W-1: col = 0, row++; if row == H-1: o_end_of_frame, go IDLE.
- tuser takes priority over tlast checks on the same beat.
- Counters 13-bit, compared against latched W-1/H-1 only.

## Timing
- All outputs registered; one-cycle latency from accept to o_data_valid.
- Reset (any time, incl. mid-frame): all outputs 0, state IDLE, counters 0, o_cfg_err 0; s_axis_tready still follows i_enable.
- i_enable low holds all state; outputs pulse only on accepted beats.
- Full throughput: one pixel per cycle.

## Configuration
- AXIS_FRAME_INGRESS_STATS_EN defined: adds o_frame_count (STAT_WIDTH, increments on o_end_of_frame, wraps) and o_err_count (STAT_WIDTH, increments on any o_err bit, saturates at all-ones); both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package axis_frame_ingress_pkg: state enum (IDLE, ACTIVE, DROP), o_err bit index constants, geometry width (13).
- One sub-module: frame_position_counter (col/row counters, clear, advance, last-column and last-row flags).

## Test plan
- W=5,H=3, 15 clean beats with tuser/tlast correct -> 15 valid outputs, SOF on 1st, EOF on 15th, o_err never set.
- W=8, tlast on 6th pixel of row 0 -> o_err[1] pulse, following beats dropped until next tuser, which restarts at (0,0).
- W=8, tlast missing at 8th pixel -> o_err[2] pulse on that pixel, DROP until tuser.
- tuser mid-frame at row 1 col 3 -> o_err[0], SOF output with that pixel, next frame completes normally.
- W=4 with KERNEL_SIZE=5 -> o_cfg_err=1, zero o_data_valid; reset asserted mid-frame -> all outputs 0 next cycle.
- With STATS_EN: 3 clean frames + 2 errors -> o_frame_count=3, o_err_count=2.

Source files
------------

// File: rtl/axis_frame_ingress_pkg.sv
// Shared types and constants for the AXI4-Stream frame ingress stage.
package axis_frame_ingress_pkg;

  localparam int GEOM_WIDTH = 13;

  localparam int ERR_EARLY_SOF  = 0;
  localparam int ERR_SHORT_LINE = 1;
  localparam int ERR_LONG_LINE  = 2;
  localparam int ERR_BITS       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } ingress_state_t;

  // A frame is usable only if every line can hold a full kernel row.
  function automatic logic geometry_legal(input logic [GEOM_WIDTH-1:0] width,
                                          input logic [GEOM_WIDTH-1:0] height,
                                          input int unsigned min_width);
    return (32'(width) >= min_width) && (height != '0);
  endfunction

endpackage

// File: rtl/axis_frame_ingress_position.sv
// Column/row tracker for the ingress stage, compared against geometry latched at SOF.
module frame_position_counter
  import axis_frame_ingress_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  load_geometry,
  input  logic [GEOM_WIDTH-1:0] width,
  input  logic [GEOM_WIDTH-1:0] height,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  advance,
  input  logic                  next_line,
  output logic                  last_col,
  output logic                  last_row
);

  logic [GEOM_WIDTH-1:0] last_col_value;
  logic [GEOM_WIDTH-1:0] last_row_value;
  logic [GEOM_WIDTH-1:0] col;
  logic [GEOM_WIDTH-1:0] row;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      last_col_value <= '0;
      last_row_value <= '0;
    end else if (load_geometry) begin
      last_col_value <= width - GEOM_WIDTH'(1);
      last_row_value <= height - GEOM_WIDTH'(1);
    end
  end

  // The SOF pixel occupies column 0, so a started frame expects column 1 next.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= GEOM_WIDTH'(1);
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (next_line) begin
      col <= '0;
      row <= row + GEOM_WIDTH'(1);
    end else if (advance) begin
      col <= col + GEOM_WIDTH'(1);
    end
  end

  assign last_col = (col == last_col_value);
  assign last_row = (row == last_row_value);

endmodule

// File: rtl/axis_frame_ingress.sv
// AXI4-Stream video to flat pixel interface with framing checks and drop-until-SOF recovery.
// Optional statistics counters are enabled with `define AXIS_FRAME_INGRESS_STATS_EN.
module axis_frame_ingress
  import axis_frame_ingress_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [GEOM_WIDTH-1:0] IMAGE_WIDTH,
  input  logic [GEOM_WIDTH-1:0] IMAGE_HEIGHT,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_start_of_frame,
  output logic                  o_end_of_frame,
  output logic [ERR_BITS-1:0]   o_err,
  output logic                  o_cfg_err
`ifdef AXIS_FRAME_INGRESS_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] o_frame_count,
  output logic [STAT_WIDTH-1:0] o_err_count
`endif
);

  ingress_state_t state_q, state_d;

  logic                accept;
  logic                geom_ok;
  logic                fwd;
  logic                sof_d;
  logic                eof_d;
  logic [ERR_BITS-1:0] err_d;
  logic                cfg_err_d;
  logic                load_geometry;
  logic                pos_start;
  logic                pos_clear;
  logic                pos_advance;
  logic                pos_next_line;
  logic                last_col;
  logic                last_row;

  assign s_axis_tready = i_enable;
  assign accept        = s_axis_tvalid & i_enable;
  assign geom_ok       = geometry_legal(IMAGE_WIDTH, IMAGE_HEIGHT, KERNEL_SIZE);

  frame_position_counter u_position (
    .i_clk         (i_clk),
    .i_areset      (i_areset),
    .load_geometry (load_geometry),
    .width         (IMAGE_WIDTH),
    .height        (IMAGE_HEIGHT),
    .clear         (pos_clear),
    .start         (pos_start),
    .advance       (pos_advance),
    .next_line     (pos_next_line),
    .last_col      (last_col),
    .last_row      (last_row)
  );

  // A tuser beat always restarts framing, even mid-frame; an illegal geometry
  // on it is discarded so the kernel buffer never sees an unusable frame.
  always_comb begin
    state_d       = state_q;
    fwd           = 1'b0;
    sof_d         = 1'b0;
    eof_d         = 1'b0;
    err_d         = '0;
    cfg_err_d     = o_cfg_err;
    load_geometry = 1'b0;
    pos_start     = 1'b0;
    pos_clear     = 1'b0;
    pos_advance   = 1'b0;
    pos_next_line = 1'b0;

    if (accept) begin
      if (s_axis_tuser) begin
        load_geometry = 1'b1;
        if (state_q == ACTIVE) begin
          err_d[ERR_EARLY_SOF] = 1'b1;
        end
        if (geom_ok) begin
          fwd       = 1'b1;
          sof_d     = 1'b1;
          cfg_err_d = 1'b0;
          pos_start = 1'b1;
          state_d   = ACTIVE;
        end else begin
          cfg_err_d = 1'b1;
          pos_clear = 1'b1;
          state_d   = IDLE;
        end
      end else if (state_q == ACTIVE) begin
        fwd = 1'b1;
        if (s_axis_tlast && !last_col) begin
          err_d[ERR_SHORT_LINE] = 1'b1;
          state_d               = DROP;
        end else if (!s_axis_tlast && last_col) begin
          err_d[ERR_LONG_LINE] = 1'b1;
          state_d              = DROP;
        end else if (s_axis_tlast) begin
          pos_next_line = 1'b1;
          if (last_row) begin
            eof_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          pos_advance = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q          <= IDLE;
      o_data           <= '0;
      o_data_valid     <= 1'b0;
      o_start_of_frame <= 1'b0;
      o_end_of_frame   <= 1'b0;
      o_err            <= '0;
      o_cfg_err        <= 1'b0;
    end else begin
      state_q          <= state_d;
      o_data_valid     <= fwd;
      o_start_of_frame <= sof_d;
      o_end_of_frame   <= eof_d;
      o_err            <= err_d;
      o_cfg_err        <= cfg_err_d;
      if (fwd) begin
        o_data <= s_axis_tdata;
      end
    end
  end

`ifdef AXIS_FRAME_INGRESS_STATS_EN
  // Frame count wraps; error count saturates so a flood of errors stays visible.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      o_frame_count <= '0;
      o_err_count   <= '0;
    end else begin
      if (eof_d) begin
        o_frame_count <= o_frame_count + STAT_WIDTH'(1);
      end
      if ((|err_d) && !(&o_err_count)) begin
        o_err_count <= o_err_count + STAT_WIDTH'(1);
      end
    end
  end
`else
  // STAT_WIDTH only shapes the optional statistics counters.
  if (STAT_WIDTH > 0) begin : g_no_stats
  end
`endif

endmodule
